// File: rtl/mc_pkg.sv
// Shared definitions for the multicycle controller.
// Holds the controller state encoding and the fixed opcode constants; aludec and the
// datapath import the same opcode constants so every block agrees on the encodings.
package mc_pkg;

  typedef enum logic [3:0] {
    StFetch    = 4'd0,
    StDecode   = 4'd1,
    StMemAdr   = 4'd2,
    StMemRd    = 4'd3,
    StMemWb    = 4'd4,
    StMemWr    = 4'd5,
    StExecute  = 4'd6,
    StAluWb    = 4'd7,
    StBranch   = 4'd8,
    StAddiExec = 4'd9,
    StAddiWb   = 4'd10,
    StJump     = 4'd11
  } state_t;

  localparam logic [5:0] OpLw    = 6'b100011;
  localparam logic [5:0] OpSw    = 6'b101011;
  localparam logic [5:0] OpSb    = 6'b101000;
  localparam logic [5:0] OpRtype = 6'b000000;
  localparam logic [5:0] OpBeq   = 6'b000100;
  localparam logic [5:0] OpBle   = 6'b000110;
  localparam logic [5:0] OpAddi  = 6'b001000;
  localparam logic [5:0] OpJ     = 6'b000010;

endpackage

// File: rtl/mc_controller.sv
// Multicycle main-decoder FSM (Moore).
// Ports:
//   clk, reset            rising-edge clock, synchronous active-high reset
//   op[5:0]               opcode field instr[31:26], held stable by the IR outside FETCH
//   memrdy                memory handshake; FETCH/MEMRD/MEMWR advance only when 1
//   memwrite, sbyte       memory write strobe and byte-lane qualifier
//   irwrite, pcwrite      instruction register load, unconditional PC load
//   branch, branchle      conditional PC load for beq (zero) / ble (zero or negative)
//   iord, regdst, memtoreg, regwrite, alusrca, alusrcb, pcsrc, aluop  datapath selects
module mc_controller
  import mc_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] op,
  input  logic       memrdy,
  output logic       memwrite,
  output logic       irwrite,
  output logic       iord,
  output logic       regdst,
  output logic       memtoreg,
  output logic       regwrite,
  output logic       alusrca,
  output logic [1:0] alusrcb,
  output logic [1:0] pcsrc,
  output logic [1:0] aluop,
  output logic       pcwrite,
  output logic       branch,
  output logic       branchle,
  output logic       sbyte
);

  state_t state_q, state_d;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StFetch;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StFetch:    state_d = memrdy ? StDecode : StFetch;
      StDecode: begin
        unique case (op)
          OpLw, OpSw, OpSb: state_d = StMemAdr;
          OpRtype:          state_d = StExecute;
          OpBeq, OpBle:     state_d = StBranch;
          OpAddi:           state_d = StAddiExec;
          OpJ:              state_d = StJump;
          default:          state_d = StFetch;  // unknown opcode: drop it silently
        endcase
      end
      StMemAdr:   state_d = (op == OpLw) ? StMemRd : StMemWr;
      StMemRd:    state_d = memrdy ? StMemWb : StMemRd;
      StMemWb:    state_d = StFetch;
      StMemWr:    state_d = memrdy ? StFetch : StMemWr;
      StExecute:  state_d = StAluWb;
      StAluWb:    state_d = StFetch;
      StBranch:   state_d = StFetch;
      StAddiExec: state_d = StAddiWb;
      StAddiWb:   state_d = StFetch;
      StJump:     state_d = StFetch;
      default:    state_d = StFetch;
    endcase
  end

  // Output decode; only FETCH looks at memrdy, and only MEMWR/BRANCH look at op.
  always_comb begin
    memwrite = 1'b0;
    irwrite  = 1'b0;
    iord     = 1'b0;
    regdst   = 1'b0;
    memtoreg = 1'b0;
    regwrite = 1'b0;
    alusrca  = 1'b0;
    alusrcb  = 2'b00;
    pcsrc    = 2'b00;
    aluop    = 2'b00;
    pcwrite  = 1'b0;
    branch   = 1'b0;
    branchle = 1'b0;
    sbyte    = 1'b0;
    unique case (state_q)
      StFetch: begin
        alusrcb = 2'b01;
        irwrite = memrdy;
        pcwrite = memrdy;
      end
      StDecode: alusrcb = 2'b11;
      StMemAdr, StAddiExec: begin
        alusrca = 1'b1;
        alusrcb = 2'b10;
      end
      StMemRd: iord = 1'b1;
      StMemWb: begin
        memtoreg = 1'b1;
        regwrite = 1'b1;
      end
      StMemWr: begin
        iord     = 1'b1;
        memwrite = 1'b1;
        sbyte    = (op == OpSb);
      end
      StExecute: begin
        alusrca = 1'b1;
        aluop   = 2'b10;
      end
      StAluWb: begin
        regdst   = 1'b1;
        regwrite = 1'b1;
      end
      StBranch: begin
        alusrca  = 1'b1;
        aluop    = 2'b01;
        pcsrc    = 2'b01;
        branch   = (op == OpBeq);
        branchle = (op == OpBle);
      end
      StAddiWb: regwrite = 1'b1;
      StJump: begin
        pcsrc   = 2'b10;
        pcwrite = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: doc/mc_controller.md
MC_CONTROLLER -- requirements
Module: mc_controller

Interface
REQ-001 SHALL have no parameters; opcode encodings are fixed package constants.
REQ-002 clk  input  1  single rising-edge clock.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 op  input  6  opcode field of instruction register, instr[31:26].
REQ-005 memrdy  input  1  memory handshake; access in FETCH/MEMRD/MEMWR completes this cycle when 1.
REQ-006 memwrite  output  1  memory write strobe.
REQ-007 irwrite  output  1  instruction register load.
REQ-008 iord  output  1  memory address select: 0 = PC, 1 = ALUOut.
REQ-009 regdst  output  1  write-register select: 0 = rt, 1 = rd.
REQ-010 memtoreg  output  1  writeback select: 0 = ALUOut, 1 = Data register.
REQ-011 regwrite  output  1  register file write enable.
REQ-012 alusrca  output  1  ALU A select: 0 = PC, 1 = register A.
REQ-013 alusrcb  output  2  ALU B select: 00 = B, 01 = 4, 10 = SignImm, 11 = SignImm<<2.
REQ-014 pcsrc  output  2  next-PC select: 00 = ALUResult, 01 = ALUOut, 10 = jump target.
REQ-015 aluop  output  2  to aludec: 00 = add, 01 = sub, 10 = use funct.
REQ-016 pcwrite  output  1  unconditional PC load.
REQ-017 branch  output  1  conditional PC load if zero (beq).
REQ-018 branchle  output  1  conditional PC load if zero or negative (ble).
REQ-019 sbyte  output  1  byte-lane store qualifier, valid with memwrite.

Function
REQ-020 SHALL be a Moore FSM; all outputs decode from state register only (memrdy gating excepted, REQ-023).
REQ-021 States: FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, EXECUTE, ALUWB, BRANCH, ADDIEXEC, ADDIWB, JUMP.
REQ-022 Opcodes: lw 100011, sw 101011, sb 101000, R-type 000000, beq 000100, ble 000110, addi 001000, j 000010.
REQ-023 FETCH: iord=0, alusrcb=01, aluop=00, pcsrc=00; irwrite=pcwrite=memrdy; stay while memrdy=0, else go to DECODE.
REQ-024 DECODE: alusrcb=11, aluop=00; next MEMADR (lw/sw/sb), EXECUTE (R), BRANCH (beq/ble), ADDIEXEC, JUMP; any other opcode -> FETCH, no side effects.
REQ-025 MEMADR: alusrca=1, alusrcb=10, aluop=00; next MEMRD (lw) or MEMWR (sw/sb).
REQ-026 MEMRD: iord=1; hold until memrdy=1, then MEMWB.
REQ-027 MEMWB: memtoreg=1, regwrite=1, regdst=0; next FETCH.
REQ-028 MEMWR: iord=1, memwrite=1, sbyte=1 iff latched op is sb; hold until memrdy=1, then FETCH; memwrite stays asserted throughout the hold.
REQ-029 EXECUTE: alusrca=1, alusrcb=00, aluop=10 -> ALUWB: regdst=1, regwrite=1 -> FETCH.
REQ-030 BRANCH: alusrca=1, alusrcb=00, aluop=01, pcsrc=01; branch=1 for beq, branchle=1 for ble; next FETCH.
REQ-031 ADDIEXEC: alusrca=1, alusrcb=10, aluop=00 -> ADDIWB: regwrite=1, regdst=0, memtoreg=0 -> FETCH.
REQ-032 JUMP: pcsrc=10, pcwrite=1; next FETCH.
REQ-033 All outputs not listed for a state SHALL be 0; no X on any output in any state.
REQ-034 With memrdy=1 throughout, instruction latency in cycles: lw 5, sw/sb 4, R 4, addi 4, beq/ble 3, j 3.
REQ-035 op SHALL be sampled in DECODE, MEMADR, MEMWR and BRANCH only; the IR holds op stable outside FETCH.

Reset
REQ-036 reset=1 at a clock edge SHALL force state to FETCH on that edge, overriding any in-progress instruction or memrdy stall.
REQ-037 While reset=1 and on the cycle after its release, state is FETCH; no write strobe (memwrite, regwrite) is asserted during reset.

Structure
REQ-038 Shared package mc_pkg SHALL hold the state enum and the eight opcode constants; aludec and the datapath import the same opcode constants.
REQ-039 No sub-module; state register plus one next-state block and one output-decode block; aludec is instantiated beside this block in the controller top, not inside it.

Verification
REQ-040 Reset for 2 cycles, memrdy=1 -> state FETCH, irwrite=pcwrite=1, all write strobes 0 on cycle 1 after release.
REQ-041 op=100011, memrdy=1 -> FETCH, DECODE, MEMADR, MEMRD, MEMWB; regwrite=1, memtoreg=1 only in cycle 5.
REQ-042 op=101000, memrdy low 3 cycles in MEMWR -> memwrite=1, sbyte=1, iord=1 for 4 cycles, then FETCH.
REQ-043 op=000110 -> BRANCH with aluop=01, branchle=1, branch=0, pcsrc=01; op=000100 -> branch=1, branchle=0.
REQ-044 op=111111 -> DECODE then FETCH; no write strobe in either cycle.
REQ-045 reset asserted in MEMRD with memrdy=0 -> FETCH next cycle; no regwrite ever asserted for the aborted lw.
